uart_rx_chan_regs: RTL
======================

Name: uart_rx_chan_regs

Overview:
- Parametrised UART receiver with a channel register bank, replacing the fixed 8-bit/4-nibble receiver of the colour mixer.
- Decodes an 8N1 serial stream (optional parity) into bytes, then into two-byte commands: address byte, then data byte.
- Writes the data byte into one of NUM_CH channel registers, e.g. red/green/blue/intensity.
- Sits between the board RX pin and the PWM/colour output stage; all logic runs on the single system clock, with no derived clocks.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per UART bit (50 MHz / 9600 baud); must be >= 4.
- NUM_CH, 4, number of channel registers, 1..64.
- CH_W, 8, channel register width, 1..8; takes the low CH_W bits of the data byte.
- ADDR_W, 2, channel index width; must be >= clog2(NUM_CH) and <= 6.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- ch_data  out  NUM_CH*CH_W  flattened channel registers; channel k occupies [k*CH_W +: CH_W].
- wr_strobe  out  1  one-cycle pulse when a channel register is written.
- wr_ch  out  ADDR_W  index of the channel last written; holds its value between writes.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse on parity mismatch; constant 0 without the macro.
- busy  out  1  high from validated start bit until the stop-bit sample.

Behaviour:
- Reset, synchronous, while reset=1: ch_data=0, wr_ch=0, wr_strobe=0, frame_err=0, parity_err=0, busy=0; bit FSM returns to IDLE and command FSM to WAIT_ADDR. Reset mid-frame abandons the frame and discards any pending address.
- rx passes through a 2-flop synchroniser initialised to 1. All timing below is relative to the synchronised signal.
- Bit FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: a low sample moves to START and clears the baud counter.
  - START: at count CLKS_PER_BIT/2 - 1 (integer division), resample. If low, go to DATA, set busy=1, clear counter. If high, treat as a glitch and return to IDLE with busy=0.
  - DATA: sample every CLKS_PER_BIT clocks, i.e. at mid-bit. Shift in 8 bits, LSB first. After bit 7, go to PARITY or STOP.
  - PARITY: sample one bit time later; compare against even parity of the 8 data bits.
  - STOP: sample one bit time later; busy=0 on the next cycle and the FSM returns to IDLE on that same cycle. A new start edge is accepted from the stop-bit midpoint.
- Byte accept rules at the stop sample:
  - rx=1 and parity OK: byte is valid.
  - rx=0: frame_err pulses, byte discarded, command FSM forced to WAIT_ADDR.
  - Parity bad, stop OK: parity_err pulses, byte discarded, command FSM forced to WAIT_ADDR.
  - Both errors: both pulses fire in the same cycle.
- Command FSM states: WAIT_ADDR, WAIT_DATA.
  - WAIT_ADDR: a valid byte with bit7=1 and bits[ADDR_W-1:0] < NUM_CH latches the index and moves to WAIT_DATA. Any other byte is silently dropped, and the FSM stays in WAIT_ADDR.
  - WAIT_DATA: any valid byte, including one with bit7=1, is data. It writes ch_data[idx] = byte[CH_W-1:0]; wr_ch=idx and wr_strobe=1 take effect on the same clock edge. The FSM then returns to WAIT_ADDR.
- Latency: the register update edge is 1 clock after the stop-bit sample edge. Other channels are never disturbed.
- Baud counter and bit counter wrap only under FSM control; no free-running wrap is observable.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - PARITY state is present; the frame is start + 8 data + even parity + stop.
  - Mismatch handling is as above.
- Not defined:
  - Frame is 8N1; PARITY state is absent.
  - parity_err is tied to 0.

Test Plan (all with CLKS_PER_BIT=16, NUM_CH=4, CH_W=8, ADDR_W=2):
- Reset, then idle rx=1 for 1000 clocks -> ch_data=0, no strobes, busy=0.
- Send 0x82 then 0x5A -> one wr_strobe, wr_ch=2, ch_data[23:16]=0x5A, other channels remain 0. Strobe edge is 1 clock after the second byte's stop sample.
- Low glitch of 4 clocks on rx, then send 0x81 then 0xC3 -> glitch ignored; ch_data[15:8]=0xC3 (data byte has bit7=1 and is still data).
- Send 0x80 with stop bit forced low -> frame_err pulses 1 cycle. A following byte 0x33 is dropped (WAIT_ADDR, bit7=0), with no write.
- Send 0x85 (index 1, valid) then 0x11 -> ch_data[15:8]=0x11. Then 0x07 (bit7=0) -> dropped with no strobe.
- UART_RX_PARITY_EN: send 0x83 with correct parity, then 0x44 with wrong parity -> parity_err pulses, no write. Resend 0x83 + 0x44 with correct parity -> ch_data[31:24]=0x44.
- Assert reset for 1 clock mid-data-byte of a 0x81/0x99 command -> no write occurs and ch_data returns to 0.

Source files
------------

// File: rtl/uart_rx_chan_regs.sv
// uart_rx_chan_regs
//   UART receiver feeding a bank of channel registers (e.g. red, green, blue,
//   intensity).  Serial bytes are decoded as 8N1 (or 8E1 when
//   UART_RX_PARITY_EN is defined), then paired into two-byte commands:
//   an address byte (bit7=1, low ADDR_W bits = channel index) followed by a
//   data byte that is written into the selected channel register.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : frame is start + 8 data + even parity + stop
//   undefined : frame is 8N1 and parity_err is tied low
//
// Ports
//   clk        system clock (all logic, no derived clocks)
//   reset      synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   ch_data    flattened channel registers, channel k at [k*CH_W +: CH_W]
//   wr_strobe  one-cycle pulse when a channel register is written
//   wr_ch      index of the channel last written (holds between writes)
//   frame_err  one-cycle pulse: stop bit sampled low
//   parity_err one-cycle pulse: parity mismatch (0 without the macro)
//   busy       high from validated start bit until the stop-bit sample
`timescale 1ns/1ps

module uart_rx_chan_regs #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int NUM_CH       = 4,
   parameter int CH_W         = 8,
   parameter int ADDR_W       = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rx,
   output logic [NUM_CH*CH_W-1:0]   ch_data,
   output logic                     wr_strobe,
   output logic [ADDR_W-1:0]        wr_ch,
   output logic                     frame_err,
   output logic                     parity_err,
   output logic                     busy
);

   localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0]   NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } bit_state_t;

   typedef enum logic {
      C_WAIT_ADDR,
      C_WAIT_DATA
   } cmd_state_t;

   // ---------------------------------------------------------------------
   // Input synchroniser, reset to the idle level so reset never looks like
   // a start bit.
   // ---------------------------------------------------------------------
   logic rx_meta, rx_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples the pre-edge value of its neighbours.
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // ---------------------------------------------------------------------
   // Bit FSM
   // ---------------------------------------------------------------------
   bit_state_t        bit_state, bit_state_nxt;
   logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
   logic [2:0]        bit_cnt, bit_cnt_nxt;
   logic [7:0]        shift_reg, shift_nxt;
   logic              busy_nxt, byte_valid, byte_valid_nxt, frame_err_nxt;
   logic              par_ok;

`ifdef UART_RX_PARITY_EN
   logic par_bit, par_bit_nxt, parity_err_nxt;
   // Even parity: data bits plus parity bit must hold an even number of ones.
   assign par_ok = ((^shift_reg) == par_bit);
`else
   assign par_ok     = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      bit_state_nxt  = bit_state;
      baud_cnt_nxt   = baud_cnt + CNT_W'(1);
      bit_cnt_nxt    = bit_cnt;
      shift_nxt      = shift_reg;
      busy_nxt       = busy;
      byte_valid_nxt = 1'b0;
      frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_nxt    = par_bit;
      parity_err_nxt = 1'b0;
`endif
      case (bit_state)
         S_IDLE: begin
            baud_cnt_nxt = '0;
            if (!rx_sync) bit_state_nxt = S_START;
         end
         S_START: begin
            // Resample at mid start bit; a high level means it was a glitch.
            if (baud_cnt == CNT_HALF) begin
               baud_cnt_nxt = '0;
               if (!rx_sync) begin
                  bit_state_nxt = S_DATA;
                  busy_nxt      = 1'b1;
                  bit_cnt_nxt   = '0;
               end else begin
                  bit_state_nxt = S_IDLE;
                  busy_nxt      = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (baud_cnt == CNT_FULL) begin
               baud_cnt_nxt = '0;
               shift_nxt    = {rx_sync, shift_reg[7:1]};   // LSB first
               bit_cnt_nxt  = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  bit_state_nxt = S_PARITY;
`else
                  bit_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (baud_cnt == CNT_FULL) begin
               baud_cnt_nxt  = '0;
               par_bit_nxt   = rx_sync;
               bit_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Returning to IDLE here lets a new start edge be seen from the
            // stop-bit midpoint onwards.
            if (baud_cnt == CNT_FULL) begin
               baud_cnt_nxt   = '0;
               bit_state_nxt  = S_IDLE;
               busy_nxt       = 1'b0;
               byte_valid_nxt = rx_sync & par_ok;
               frame_err_nxt  = ~rx_sync;
`ifdef UART_RX_PARITY_EN
               parity_err_nxt = ~par_ok;
`endif
            end
         end
         default: begin
            bit_state_nxt = S_IDLE;
            busy_nxt      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_state  <= S_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         busy       <= 1'b0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         bit_state  <= bit_state_nxt;
         baud_cnt   <= baud_cnt_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift_reg  <= shift_nxt;
         busy       <= busy_nxt;
         byte_valid <= byte_valid_nxt;
         frame_err  <= frame_err_nxt;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bit    <= par_bit_nxt;
         parity_err <= parity_err_nxt;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Command FSM: address byte, then data byte.  shift_reg still holds the
   // received byte in the cycle byte_valid is high.
   // ---------------------------------------------------------------------
   cmd_state_t        cmd_state, cmd_state_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic              wr_en;

   always_comb begin
      cmd_state_nxt = cmd_state;
      idx_nxt       = idx;
      wr_en         = 1'b0;
      if (frame_err || parity_err) begin
         // A corrupted byte abandons any half-received command.
         cmd_state_nxt = C_WAIT_ADDR;
      end else if (byte_valid) begin
         case (cmd_state)
            C_WAIT_ADDR: begin
               if (shift_reg[7] && ({1'b0, shift_reg[ADDR_W-1:0]} < NUM_CH_L)) begin
                  idx_nxt       = shift_reg[ADDR_W-1:0];
                  cmd_state_nxt = C_WAIT_DATA;
               end
            end
            C_WAIT_DATA: begin
               wr_en         = 1'b1;
               cmd_state_nxt = C_WAIT_ADDR;
            end
            default: cmd_state_nxt = C_WAIT_ADDR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_state <= C_WAIT_ADDR;
         idx       <= '0;
         wr_ch     <= '0;
         wr_strobe <= 1'b0;
         // NOTE: the channel bank is a handful of flops that drive visible
         // outputs, so it is reset explicitly rather than treated as RAM.
         ch_data   <= '0;
      end else begin
         cmd_state <= cmd_state_nxt;
         idx       <= idx_nxt;
         wr_strobe <= wr_en;
         if (wr_en) begin
            wr_ch <= idx;
            for (int k = 0; k < NUM_CH; k++) begin
               if (idx == ADDR_W'(k)) ch_data[k*CH_W +: CH_W] <= shift_reg[CH_W-1:0];
            end
         end
      end
   end

endmodule
